// File: rtl/blake_pkg.sv
// Shared definitions for the BLAKE nonce sequencer.
// Holds the sequencer state encoding, the fixed header and hash widths of
// the hash core, and the default nonce width, compare width and timeout.
package blake_pkg;

    localparam int HDR_W       = 640;
    localparam int HASH_W      = 512;
    localparam int NONCE_W_DEF = 32;
    localparam int CMP_W_DEF   = 64;
    localparam int TIMEOUT_DEF = 1023;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_REPORT = 3'd3,
        S_DRAIN  = 3'd4
    } state_e;

endpackage

// File: rtl/blake_target_cmp.sv
// Unsigned less-or-equal comparator between the top bits of a hash and the
// job target.
//   value_i  : hash bits under test
//   target_i : threshold
//   le_o     : 1 when value_i <= target_i
module blake_target_cmp #(
    parameter int W = 64
) (
    input  logic [W-1:0] value_i,
    input  logic [W-1:0] target_i,
    output logic         le_o
);

    assign le_o = (value_i <= target_i);

endmodule

// File: rtl/blake_nonce_sequencer.sv
// Walks a nonce range for a BLAKE hash core. Each nonce is spliced into the
// low bits of the header, issued with a one-cycle core_ena, and the core's
// answer is compared against the target; hits are offered on the result
// handshake. Supports wrap-around ranges, abort, and a core timeout.
//   clk, rstb                    : clock, async active-low reset
//   job_*                        : job handshake and range/target/header
//   abort                        : cancel the running job
//   core_din/core_ena            : header+nonce and start pulse to the core
//   core_rdy/core_dout           : done pulse and hash from the core
//   res_*                        : hit handshake (nonce and hash)
//   busy, done, err_timeout      : status
module blake_nonce_sequencer
    import blake_pkg::*;
#(
    parameter int NONCE_W = NONCE_W_DEF,
    parameter int CMP_W   = CMP_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [HDR_W-1:0]   job_header,
    input  logic [NONCE_W-1:0] job_nonce_start,
    input  logic [NONCE_W-1:0] job_nonce_end,
    input  logic [CMP_W-1:0]   job_target,
    input  logic               abort,
    output logic [HDR_W-1:0]   core_din,
    output logic               core_ena,
    input  logic               core_rdy,
    input  logic [HASH_W-1:0]  core_dout,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [NONCE_W-1:0] res_nonce,
    output logic [HASH_W-1:0]  res_hash,
    output logic               busy,
    output logic               done,
    output logic               err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    // The live nonce is kept in the low bits of the header register so the
    // core input is a plain register and stays stable until core_rdy.
    logic [HDR_W-1:0]   hdr_q, hdr_d;
    logic [NONCE_W-1:0] end_q, end_d;
    logic [CMP_W-1:0]   tgt_q, tgt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NONCE_W-1:0] res_nonce_q, res_nonce_d;
    logic [HASH_W-1:0]  res_hash_q, res_hash_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               rdy_q, rdy_d;
    logic               hit;
    logic               advance;
    logic [NONCE_W-1:0] nonce;

    assign nonce = hdr_q[NONCE_W-1:0];

    blake_target_cmp #(.W(CMP_W)) u_cmp (
        .value_i  (core_dout[HASH_W-1 -: CMP_W]),
        .target_i (tgt_q),
        .le_o     (hit)
    );

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        end_d       = end_q;
        tgt_d       = tgt_q;
        cnt_d       = cnt_q;
        res_nonce_d = res_nonce_q;
        res_hash_d  = res_hash_q;
        err_d       = err_q;
        done_d      = 1'b0;
        advance     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (job_valid && rdy_q) begin
                    hdr_d   = {job_header[HDR_W-1:NONCE_W], job_nonce_start};
                    end_d   = job_nonce_end;
                    tgt_d   = job_target;
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (abort) begin
                    // A result arriving with abort is already the drained
                    // answer, so there is nothing left to wait for.
                    state_d = core_rdy ? S_IDLE : S_DRAIN;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (core_rdy) begin
                    if (hit) begin
                        res_nonce_d = nonce;
                        res_hash_d  = core_dout;
                        state_d     = S_REPORT;
                    end else begin
                        advance = 1'b1;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REPORT: begin
                if (abort)          state_d = S_IDLE;
                else if (res_ready) advance = 1'b1;
            end
            S_DRAIN: begin
                // Counter carries over from WAIT, so the total wait on the
                // core is still bounded by TIMEOUT.
                if (core_rdy) begin
                    state_d = S_IDLE;
                end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (nonce == end_q) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end else begin
                hdr_d[NONCE_W-1:0] = nonce + NONCE_W'(1);
                state_d            = S_ISSUE;
            end
        end

        // Registered so job_ready stays low while reset is held.
        rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= S_IDLE;
            hdr_q       <= '0;
            end_q       <= '0;
            tgt_q       <= '0;
            cnt_q       <= '0;
            res_nonce_q <= '0;
            res_hash_q  <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            end_q       <= end_d;
            tgt_q       <= tgt_d;
            cnt_q       <= cnt_d;
            res_nonce_q <= res_nonce_d;
            res_hash_q  <= res_hash_d;
            err_q       <= err_d;
            done_q      <= done_d;
            rdy_q       <= rdy_d;
        end
    end

    assign job_ready   = rdy_q;
    assign core_din    = hdr_q;
    assign core_ena    = (state_q == S_ISSUE);
    assign res_valid   = (state_q == S_REPORT);
    assign res_nonce   = res_nonce_q;
    assign res_hash    = res_hash_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_blake_nonce_sequencer.sv
// Directed bench for blake_nonce_sequencer with an 8-bit nonce, 64-bit
// compare and a 15-cycle timeout, driven against a behavioural hash core.
module tb_blake_nonce_sequencer;

    localparam int NW = 8;
    localparam int CW = 64;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [639:0]  job_header = '0;
    logic [NW-1:0] job_nonce_start = '0;
    logic [NW-1:0] job_nonce_end = '0;
    logic [CW-1:0] job_target = '0;
    logic          abort = 1'b0;
    logic [639:0]  core_din;
    logic          core_ena;
    logic          core_rdy;
    logic [511:0]  core_dout;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [NW-1:0] res_nonce;
    logic [511:0]  res_hash;
    logic          busy;
    logic          done;
    logic          err_timeout;

    always #5 clk = ~clk;

    blake_nonce_sequencer #(.NONCE_W(NW), .CMP_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstb(rstb),
        .job_valid(job_valid), .job_ready(job_ready), .job_header(job_header),
        .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end),
        .job_target(job_target), .abort(abort),
        .core_din(core_din), .core_ena(core_ena), .core_rdy(core_rdy),
        .core_dout(core_dout),
        .res_valid(res_valid), .res_ready(res_ready), .res_nonce(res_nonce),
        .res_hash(res_hash),
        .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    localparam logic [639:0] HDR = {20{32'hDEADBEEF}};

    int n_checks = 0;
    int n_fail   = 0;

    // core model controls
    int         lat = 1;
    bit         mute = 1'b0;
    bit         spec_en = 1'b0;
    logic [7:0] spec_n = '0;
    int         cnt_down = -1;
    logic [7:0] pend_n = '0;

    // monitor state
    int          ena_cnt = 0, done_cnt = 0, res_cnt = 0, hash_bad = 0;
    logic [31:0] iss_log = '0, res_log = '0;

    // Hash top bits are nonzero (miss for target 0) except for the special nonce.
    function automatic logic [511:0] hash_of(input logic [7:0] n);
        logic [63:0] top;
        top = (spec_en && n == spec_n) ? 64'h0 : {1'b1, 55'h0, n};
        return {top, {56{n}}};
    endfunction

    initial begin
        core_rdy  = 1'b0;
        core_dout = '0;
        forever begin
            @(negedge clk);
            core_rdy = 1'b0;
            if (!rstb) cnt_down = -1;
            if (cnt_down > 0) begin
                cnt_down--;
                if (cnt_down == 0) begin
                    core_rdy  = 1'b1;
                    core_dout = hash_of(pend_n);
                    cnt_down  = -1;
                end
            end else if (core_ena && !mute) begin
                pend_n   = core_din[7:0];
                cnt_down = lat;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (core_ena) begin
                ena_cnt++;
                iss_log = {iss_log[23:0], core_din[7:0]};
            end
            if (done) done_cnt++;
            if (res_valid && res_ready) begin
                res_cnt++;
                res_log = {res_log[23:0], res_nonce};
                if (res_hash !== hash_of(res_nonce)) hash_bad++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task clr;
        ena_cnt = 0; done_cnt = 0; res_cnt = 0; hash_bad = 0;
        iss_log = '0; res_log = '0;
    endtask

    task send_job(input logic [7:0] s, input logic [7:0] e, input logic [63:0] t);
        @(negedge clk);
        job_valid = 1'b1; job_header = HDR;
        job_nonce_start = s; job_nonce_end = e; job_target = t;
        n_checks++;
        if (job_ready !== 1'b1) begin
            n_fail++; $display("FAIL job_ready_before_accept got=%b exp=1", job_ready);
        end
        @(negedge clk);
        job_valid = 1'b0;
        n_checks++;
        if (core_ena !== 1'b1 || core_din !== {HDR[639:8], s}) begin
            n_fail++;
            $display("FAIL first_issue ena=%b din_lo=%h exp ena=1 din_lo=%h",
                     core_ena, core_din[7:0], s);
        end
    endtask

    task test_reset;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({job_ready, busy, core_ena, res_valid, done, err_timeout} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {job_ready, busy, core_ena, res_valid, done, err_timeout});
        end
        n_checks++;
        if (core_din !== '0 || res_hash !== '0 || res_nonce !== '0) begin
            n_fail++; $display("FAIL reset_data din_lo=%h nonce=%h exp 0", core_din[31:0], res_nonce);
        end
        rstb = 1'b1;
        @(negedge clk);
        n_checks++;
        if (job_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ready_after_reset ready=%b busy=%b exp 1 0", job_ready, busy);
        end
    endtask

    task test_range;
        int n;
        clr; spec_en = 1'b0; lat = 1; res_ready = 1'b1;
        send_job(8'd5, 8'd7, {64{1'b1}});
        n = 0;
        while (done_cnt == 0 && n < 80) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        n_checks++;
        if (ena_cnt !== 3 || iss_log[23:0] !== 24'h050607) begin
            n_fail++; $display("FAIL range_issue cnt=%0d log=%h exp 3 050607", ena_cnt, iss_log[23:0]);
        end
        n_checks++;
        if (res_cnt !== 3 || res_log[23:0] !== 24'h050607 || hash_bad !== 0) begin
            n_fail++;
            $display("FAIL range_results cnt=%0d log=%h bad=%0d exp 3 050607 0",
                     res_cnt, res_log[23:0], hash_bad);
        end
        n_checks++;
        if (done_cnt !== 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL range_done done=%0d busy=%b exp 1 0", done_cnt, busy);
        end
    endtask

    task test_wrap;
        int n;
        clr; spec_en = 1'b0; res_ready = 1'b1;
        send_job(8'hFF, 8'h01, 64'h0);
        n = 0;
        while (done_cnt == 0 && n < 80) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        n_checks++;
        if (ena_cnt !== 3 || iss_log[23:0] !== 24'hFF0001) begin
            n_fail++; $display("FAIL wrap_issue cnt=%0d log=%h exp 3 ff0001", ena_cnt, iss_log[23:0]);
        end
        n_checks++;
        if (res_cnt !== 0 || done_cnt !== 1) begin
            n_fail++; $display("FAIL wrap_done res=%0d done=%0d exp 0 1", res_cnt, done_cnt);
        end
    endtask

    task test_hold;
        int n;
        int bad;
        clr; spec_en = 1'b1; spec_n = 8'd3; res_ready = 1'b0;
        send_job(8'd2, 8'd5, 64'h0);
        n = 0;
        while (res_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        n_checks++;
        if (res_valid !== 1'b1) begin
            n_fail++; $display("FAIL hold_wait_valid got=%b exp=1", res_valid);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_nonce !== 8'd3 || res_hash !== hash_of(8'd3) || core_ena !== 1'b0)
                bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL hold_stable unstable_cycles=%0d exp 0", bad);
        end
        n_checks++;
        if (ena_cnt !== 2 || iss_log[15:0] !== 16'h0203) begin
            n_fail++; $display("FAIL hold_no_issue cnt=%0d log=%h exp 2 0203", ena_cnt, iss_log[15:0]);
        end
        res_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (core_ena !== 1'b1 || core_din[7:0] !== 8'd4 || res_cnt !== 1 || res_log[7:0] !== 8'd3) begin
            n_fail++;
            $display("FAIL hold_next ena=%b nonce=%h res=%0d/%h exp 1 04 1/03",
                     core_ena, core_din[7:0], res_cnt, res_log[7:0]);
        end
        n = 0;
        while (done_cnt == 0 && n < 80) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        n_checks++;
        if (iss_log !== 32'h02030405 || done_cnt !== 1 || hash_bad !== 0) begin
            n_fail++;
            $display("FAIL hold_end log=%h done=%0d bad=%0d exp 02030405 1 0", iss_log, done_cnt, hash_bad);
        end
        spec_en = 1'b0;
    endtask

    task test_abort;
        clr; lat = 4; res_ready = 1'b1;
        send_job(8'd0, 8'd9, 64'h0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL abort_drain_busy got=%b exp=1", busy);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || job_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_idle busy=%b ready=%b exp 0 1", busy, job_ready);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (ena_cnt !== 1 || done_cnt !== 0 || res_cnt !== 0) begin
            n_fail++;
            $display("FAIL abort_quiet ena=%0d done=%0d res=%0d exp 1 0 0", ena_cnt, done_cnt, res_cnt);
        end
        lat = 1;
    endtask

    task test_timeout;
        int n;
        clr; mute = 1'b1;
        send_job(8'd0, 8'd3, 64'h0);
        repeat (15) @(negedge clk);
        n_checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL timeout_early err=%b busy=%b exp 0 1", err_timeout, busy);
        end
        @(negedge clk);
        n_checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_fire err=%b busy=%b exp 1 0", err_timeout, busy);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (err_timeout !== 1'b1 || done_cnt !== 0 || ena_cnt !== 1) begin
            n_fail++;
            $display("FAIL timeout_sticky err=%b done=%0d ena=%0d exp 1 0 1", err_timeout, done_cnt, ena_cnt);
        end
        mute = 1'b0;
        clr;
        send_job(8'd7, 8'd7, {64{1'b1}});
        n_checks++;
        if (err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout_clear got=%b exp=0", err_timeout);
        end
        n = 0;
        while (done_cnt == 0 && n < 40) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        n_checks++;
        if (done_cnt !== 1 || res_cnt !== 1 || res_log[7:0] !== 8'd7) begin
            n_fail++;
            $display("FAIL timeout_next_job done=%0d res=%0d nonce=%h exp 1 1 07", done_cnt, res_cnt, res_log[7:0]);
        end
    endtask

    task test_reset_report;
        int n;
        clr; spec_en = 1'b1; spec_n = 8'd3; res_ready = 1'b0;
        send_job(8'd3, 8'd3, 64'h0);
        n = 0;
        while (res_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        n_checks++;
        if (res_valid !== 1'b1) begin
            n_fail++; $display("FAIL rr_wait_valid got=%b exp=1", res_valid);
        end
        @(negedge clk);
        #2 rstb = 1'b0;
        #1;
        n_checks++;
        if ({job_ready, busy, core_ena, res_valid, done, err_timeout} !== 6'b0 ||
            res_nonce !== '0 || res_hash !== '0 || core_din !== '0) begin
            n_fail++;
            $display("FAIL rr_outputs flags=%b nonce=%h exp 000000 00",
                     {job_ready, busy, core_ena, res_valid, done, err_timeout}, res_nonce);
        end
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        n_checks++;
        if (job_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++; $display("FAIL rr_release ready=%b valid=%b exp 1 0", job_ready, res_valid);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (ena_cnt !== 1 || done_cnt !== 0 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_quiet ena=%0d done=%0d valid=%b exp 1 0 0", ena_cnt, done_cnt, res_valid);
        end
        spec_en = 1'b0; res_ready = 1'b1;
    endtask

    initial begin
        test_reset;
        test_range;
        test_wrap;
        test_hold;
        test_abort;
        test_timeout;
        test_reset_report;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/blake_nonce_sequencer.md
BLAKE_NONCE_SEQUENCER -- requirements
Module: blake_nonce_sequencer

Interface
REQ-001 SHALL have parameter NONCE_W, default 32, nonce width.
REQ-002 SHALL have parameter CMP_W, default 64, number of hash bits compared against the target.
REQ-003 SHALL have parameter TIMEOUT, default 1023, maximum cycles spent waiting for the core.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rstb  input  1  asynchronous, active-low reset.
REQ-006 job_valid  input  1  job offered.
REQ-007 job_ready  output  1  job accepted when both valid and ready are high.
REQ-008 job_header  input  640  header template; bits [NONCE_W-1:0] are overwritten by the nonce.
REQ-009 job_nonce_start  input  NONCE_W  first nonce.
REQ-010 job_nonce_end  input  NONCE_W  last nonce, inclusive.
REQ-011 job_target  input  CMP_W  hit threshold.
REQ-012 abort  input  1  cancel current job.
REQ-013 core_din  output  640  header with nonce, driven to the hash core.
REQ-014 core_ena  output  1  one-cycle start pulse to the core.
REQ-015 core_rdy  input  1  one-cycle done pulse from the core.
REQ-016 core_dout  input  512  hash result, valid with core_rdy.
REQ-017 res_valid  output  1  hit available.
REQ-018 res_ready  input  1  hit consumed when both valid and ready are high.
REQ-019 res_nonce  output  NONCE_W  nonce that produced the hit.
REQ-020 res_hash  output  512  hash of the hit.
REQ-021 busy  output  1  high in every state except IDLE.
REQ-022 done  output  1  one-cycle pulse when the range is exhausted.
REQ-023 err_timeout  output  1  sticky flag; set when the core fails to answer in time.

Function
REQ-024 States SHALL be IDLE, ISSUE, WAIT, REPORT, DRAIN.
- IDLE: job_ready=1.
- On job acceptance, register header, start, end and target; set nonce=start; go to ISSUE.
REQ-025 ISSUE SHALL assert core_ena for exactly one cycle, then go to WAIT.
- core_din = {header[639:NONCE_W], nonce}.
- First core_ena occurs the cycle after acceptance.
REQ-026 core_din SHALL remain stable from ISSUE until core_rdy has been sampled.
REQ-027 In WAIT, on core_rdy, hit = (core_dout[511:512-CMP_W] <= target), compared unsigned.
REQ-028 On a hit, the block SHALL capture nonce and core_dout into res_nonce and res_hash, assert res_valid and go to REPORT.
REQ-029 REPORT SHALL hold res_valid and its data stable until res_ready is sampled high.
REQ-030 On a miss, or when leaving REPORT:
- if nonce == end: pulse done, go to IDLE;
- otherwise nonce = nonce+1 (mod 2^NONCE_W), go to ISSUE.
REQ-031 Wrap-around SHALL be legal.
- end < start iterates through all-ones to 0.
- start == end yields exactly one hash.
- start=0, end=all-ones yields 2^NONCE_W hashes.
REQ-032 WAIT SHALL count cycles. If TIMEOUT cycles elapse without core_rdy: set err_timeout, drop the job, go to IDLE without pulsing done.
REQ-033 err_timeout SHALL clear only on acceptance of the next job.
REQ-034 abort SHALL apply as follows:
- in ISSUE or REPORT: go to IDLE next cycle, deassert res_valid, no done pulse;
- in WAIT: go to DRAIN, which waits for core_rdy (or timeout), discards the result, then goes to IDLE;
- in IDLE: ignored.
REQ-035 Priority SHALL be abort over res_ready, and abort over core_rdy (the result is discarded).
REQ-036 core_rdy outside WAIT or DRAIN SHALL be ignored.

Reset
REQ-037 While rstb=0, the block SHALL hold state IDLE, all outputs 0, job_ready=0, and all registers 0.
REQ-038 job_ready SHALL assert in the first clock cycle after rstb deasserts.
REQ-039 Reset mid-job SHALL abandon the job with no done pulse, no result, and no core_ena.

Structure
REQ-040 A shared package blake_pkg SHALL hold:
- the state enum;
- HDR_W=640 and HASH_W=512;
- the default NONCE_W, CMP_W and TIMEOUT.
REQ-041 The block SHALL use one sub-module, blake_target_cmp: combinational, CMP_W-bit unsigned less-or-equal comparator.

Verification
REQ-042 Range start=5, end=7, target=all-ones, ideal core model -> 3 core_ena pulses, 3 results with nonces 5, 6, 7, then a done pulse.
REQ-043 start=all-ones, end=1, target=0, no hash top bits zero -> nonces issued all-ones, 0, 1; no res_valid; done pulse.
REQ-044 Hit on nonce 3, res_ready held low 20 cycles -> res_valid and data stable for 20 cycles; nonce 4 issued only after the handshake.
REQ-045 abort while in WAIT -> no new core_ena; core_rdy discarded; busy drops the cycle after core_rdy; no done pulse.
REQ-046 Core model never asserts core_rdy, TIMEOUT=15 -> err_timeout set 15 cycles after core_ena; IDLE; next job acceptance clears err_timeout.
REQ-047 rstb asserted during REPORT -> all outputs 0 immediately; after release, job_ready=1 and no stale res_valid.
